// File: rtl/ultrasonic_echo_receiver.sv
// ============================================================================
// ultrasonic_echo_receiver : 40 kHz echo burst qualifier with time-of-flight timer.
// Optional build macro: ECHO_GLITCH_FILTER_EN (3-tap majority filter).  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ultrasonic_echo_receiver #(
  parameter int PERIOD_NOM     = 1250,
  parameter int PERIOD_TOL     = 62,
  parameter int LOCK_CYCLES    = 4,
  parameter int BLANK_CYCLES   = 10000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TOF_W          = 20
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             rx_in,
  output logic             busy,
  output logic [TOF_W-1:0] tof,
  output logic             tof_valid,
  output logic             timeout,
  output logic [10:0]      last_period
);

  localparam int              c_vw         = $clog2(LOCK_CYCLES + 1);
  localparam logic [10:0]     c_pmax       = 11'd2047;
  localparam logic [10:0]     c_win_lo     = 11'(PERIOD_NOM - PERIOD_TOL);
  localparam logic [10:0]     c_win_hi     = 11'(PERIOD_NOM + PERIOD_TOL);
  localparam logic [TOF_W-1:0] c_blank_end = TOF_W'(BLANK_CYCLES - 1);
  localparam logic [TOF_W-1:0] c_tmo_end   = TOF_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_vw-1:0] c_lock_last  = c_vw'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BLANK  = 2'd1,
    S_LISTEN = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_clean_d;
  logic              r_edge;
  logic              w_clean;
  logic [TOF_W-1:0]  r_timer;
  logic [10:0]       r_pcnt;
  logic              r_run;
  logic [TOF_W-1:0]  r_run_start;
  logic [c_vw-1:0]   r_valid_cnt;
  logic [10:0]       w_period;
  logic              w_in_win;
  logic              w_lock;
  logic              w_tmo;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef ECHO_GLITCH_FILTER_EN
  logic r_tap1;
  logic r_tap2;
  logic r_filt;

  // Majority over three consecutive samples rejects single-clock pulses.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_tap1 <= 1'b0;
      r_tap2 <= 1'b0;
      r_filt <= 1'b0;
    end else begin
      r_tap1 <= r_sync2;
      r_tap2 <= r_tap1;
      r_filt <= (r_sync2 & r_tap1) | (r_sync2 & r_tap2) | (r_tap1 & r_tap2);
    end
  end

  assign w_clean = r_filt;
`else
  assign w_clean = r_sync2;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_clean_d <= 1'b0;
      r_edge    <= 1'b0;
    end else begin
      r_clean_d <= w_clean;
      r_edge    <= w_clean & ~r_clean_d;
    end
  end

  // The counter reads one less than the edge spacing when the next edge arrives.
  assign w_period = (r_pcnt == c_pmax) ? c_pmax : r_pcnt + 11'd1;
  assign w_in_win = (w_period >= c_win_lo) && (w_period <= c_win_hi);
  assign w_lock   = (r_state == S_LISTEN) && r_edge && r_run && w_in_win &&
                    (r_valid_cnt == c_lock_last);
  assign w_tmo    = (r_state != S_IDLE) && (r_timer == c_tmo_end);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_pcnt      <= '0;
      r_run       <= 1'b0;
      r_run_start <= '0;
      r_valid_cnt <= '0;
      busy        <= 1'b0;
      tof         <= '0;
      tof_valid   <= 1'b0;
      timeout     <= 1'b0;
      last_period <= '0;
    end else begin
      tof_valid <= 1'b0;
      timeout   <= 1'b0;

      if (r_edge) begin
        last_period <= w_period;
      end

      if (r_state == S_BLANK) begin
        r_pcnt <= c_pmax;
      end else if (r_edge) begin
        r_pcnt <= '0;
      end else if (r_pcnt != c_pmax) begin
        r_pcnt <= r_pcnt + 11'd1;
      end

      if (w_lock) begin
        tof       <= r_run_start;
        tof_valid <= 1'b1;
      end else if (w_tmo) begin
        timeout <= 1'b1;
      end

      if (start) begin
        r_state     <= S_BLANK;
        r_timer     <= '0;
        r_run       <= 1'b0;
        r_valid_cnt <= '0;
        busy        <= 1'b1;
      end else if (w_lock || w_tmo) begin
        r_state <= S_IDLE;
        r_run   <= 1'b0;
        busy    <= 1'b0;
      end else if (r_state != S_IDLE) begin
        r_timer <= r_timer + TOF_W'(1);
        if (r_state == S_BLANK) begin
          if (r_timer == c_blank_end) begin
            r_state     <= S_LISTEN;
            r_run       <= 1'b0;
            r_valid_cnt <= '0;
          end
        end else if (r_edge) begin
          if (!r_run || !w_in_win) begin
            r_run_start <= r_timer;
            r_valid_cnt <= '0;
            r_run       <= 1'b1;
          end else begin
            r_valid_cnt <= r_valid_cnt + c_vw'(1);
          end
        end else if (r_pcnt > c_win_hi) begin
          r_run <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire
